axi_burst_master: RTL

- AXI3-style initiator that drives the write (AW/W/B) and read (AR/R) channels toward an AXI slave, such as the memory on the team's `axi_if` bench.
- Takes one burst command at a time from a simple valid/ready command port.
- Streams write data in and read data out.
- Reports completion with the response code and a protocol-error flag.
- One outstanding transaction; channel phases are strictly sequential.

---
 rtl/axi_burst_master.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_master.sv
// AXI3 burst initiator: one outstanding write or read burst, with strictly sequential phases.
// Optional AXI_MASTER_4K_CHECK_EN rejects INCR commands that would cross a 4 KB boundary.
module axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [1:0]        cmd_burst,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_rlast,
    output logic              m_rvalid,
    input  logic              m_rready,
    output logic              done,
    output logic [1:0]        done_resp,
    output logic              done_err,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   awid,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [ADDR_W-1:0] awaddr,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [ID_W-1:0]   arid,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [ADDR_W-1:0] araddr,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp
);
    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [1:0]        r_burst;
    logic [ID_W-1:0]   r_id;
    logic [3:0]        r_beat;
    logic [1:0]        r_resp;
    logic              r_err;
    logic              r_cmd_ready;
    logic              r_awvalid;
    logic              r_arvalid;
    logic              r_bready;
    logic              r_done;

    logic w_wr_data;
    logic w_rd_data;
    logic w_wfire;
    logic w_rfire;
    logic w_last_beat;
    logic w_4k_cross;

    assign w_wr_data   = (r_state == WR_DATA);
    assign w_rd_data   = (r_state == RD_DATA);
    assign w_wfire     = w_wr_data & s_wvalid & wready;
    assign w_rfire     = w_rd_data & rvalid & m_rready;
    assign w_last_beat = (r_beat == r_len);

`ifdef AXI_MASTER_4K_CHECK_EN
    // Last byte offset is addr + len*4 + 3; a carry into bit 12 means the burst leaves its 4 KB page.
    logic [12:0] w_4k_end;
    assign w_4k_end   = {1'b0, cmd_addr[11:0]} + {7'b0, cmd_len, 2'b00} + 13'd3;
    assign w_4k_cross = (cmd_burst == 2'b01) & w_4k_end[12];
`else
    assign w_4k_cross = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign done      = r_done;
    assign done_resp = r_resp;
    assign done_err  = r_err;

    assign awvalid = r_awvalid;
    assign awid    = r_id;
    assign awlen   = r_len;
    assign awsize  = 3'b010;
    assign awaddr  = r_addr;
    assign awburst = r_burst;
    assign arvalid = r_arvalid;
    assign arid    = r_id;
    assign arlen   = r_len;
    assign arsize  = 3'b010;
    assign araddr  = r_addr;
    assign arburst = r_burst;

    // Data channels are combinational pass-throughs, gated so nothing leaks outside the data phase.
    assign wvalid   = w_wr_data & s_wvalid;
    assign s_wready = w_wr_data & wready;
    assign wdata    = w_wr_data ? s_wdata : '0;
    assign wid      = r_id;
    assign wstrb    = 4'hF;
    assign wlast    = w_wr_data & w_last_beat;
    assign bready   = r_bready;
    assign rready   = w_rd_data & m_rready;
    assign m_rvalid = w_rd_data & rvalid;
    assign m_rdata  = w_rd_data ? rdata : '0;
    assign m_rlast  = w_rd_data & rlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_id        <= '0;
            r_beat      <= '0;
            r_resp      <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_addr      <= cmd_addr;
                        r_len       <= cmd_len;
                        r_burst     <= cmd_burst;
                        r_id        <= cmd_id;
                        r_beat      <= '0;
                        r_resp      <= '0;
                        r_err       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        if (w_4k_cross) begin
                            r_resp  <= 2'b10;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= WR_ADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_wfire) begin
                        r_beat <= r_beat + 4'd1;
                        if (w_last_beat) begin
                            r_bready <= 1'b1;
                            r_state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        r_resp   <= bresp;
                        r_err    <= r_err | (bid != r_id);
                        r_bready <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_rfire) begin
                        r_beat <= r_beat + 4'd1;
                        // Keep the first error response; later beats must not overwrite it.
                        if (r_resp == 2'b00)
                            r_resp <= rresp;
                        r_err <= r_err | (rid != r_id) | (rlast != w_last_beat);
                        if (w_last_beat) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
